// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the alu_wb writeback ALU.
//   op_t     - 3-bit opcode encoding driven by the issuing controller.
//   state_t  - alu_wb control FSM states.
//   sat_bw() - signed saturation bound for a bw-bit result. The caller
//              size-casts the value down to its own width.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_MUL   = 3'd5,
        OP_PASSA = 3'd6,
        OP_SRA   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int SAT_MAX_W = 64;

    // neg=1 -> -2^(bw-1), neg=0 -> 2^(bw-1)-1.
    // Only the low bw bits of the return value are meaningful.
    function automatic logic [SAT_MAX_W-1:0] sat_bw(input logic neg, input int unsigned bw);
        if (neg) sat_bw = {SAT_MAX_W{1'b1}} << (bw - 1);
        else     sat_bw = (SAT_MAX_W'(1) << (bw - 1)) - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/alu_wb_if.sv
// alu_wb_if: issue and writeback bus between the controller, alu_wb and the RF.
//   op_valid/op_ready           - issue handshake
//   opcode, dst_addr            - operation and writeback register
//   operand_a/operand_b         - signed operands from the RF read ports
//   wb_data/wb_addr/wb_en_n     - RF write port (wb_en_n is active low)
//   ovf                         - overflow flag of the last written-back op
// master = controller side, slave = alu_wb.
interface alu_wb_if import alu_pkg::*; #(
    parameter int BW    = 8,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic                 op_valid;
    logic                 op_ready;
    op_t                  opcode;
    logic [AW-1:0]        dst_addr;
    logic signed [BW-1:0] operand_a;
    logic signed [BW-1:0] operand_b;
    logic signed [BW-1:0] wb_data;
    logic [AW-1:0]        wb_addr;
    logic                 wb_en_n;
    logic                 ovf;

    modport master (
        output op_valid, opcode, dst_addr, operand_a, operand_b,
        input  op_ready, wb_data, wb_addr, wb_en_n, ovf
    );

    modport slave (
        input  op_valid, opcode, dst_addr, operand_a, operand_b,
        output op_ready, wb_data, wb_addr, wb_en_n, ovf
    );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative signed multiplier. It uses BW shift-add steps over
// the operand magnitudes and then applies the sign.
//   clk, rst  - clock, synchronous active-high reset
//   start     - load a/b. The first step runs on the next edge.
//   busy      - iterations in progress
//   done      - high during the cycle whose closing edge does the last step
//   product   - 2*BW-bit signed product. It is valid while done is high and
//               already includes that final step, so the caller can register
//               it on the same edge.
module alu_mul_iter #(
    parameter int BW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [BW-1:0]   a,
    input  logic signed [BW-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic signed [2*BW-1:0] product
);
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    logic [2*BW-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [BW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d, busy_q, busy_d;

    // Magnitude fits in BW unsigned bits. This includes -2^(BW-1).
    function automatic logic [BW-1:0] mag(input logic [BW-1:0] v);
        return v[BW-1] ? (~v + 1'b1) : v;
    endfunction

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CW'(BW - 1));
    assign busy     = busy_q;
    assign product  = $signed(neg_q ? (~acc_step + 1'b1) : acc_step);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{BW{1'b0}}, mag(a)};
            mplier_d = mag(b);
            cnt_d    = '0;
            neg_d    = a[BW-1] ^ b[BW-1];
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // Always BW steps, even when the multiplier runs out of ones early.
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_wb.sv
// alu_wb: multi-cycle signed ALU that writes its result back through the RF
// write port.
//   clk, rst - clock, synchronous active-high reset
//   bus      - alu_wb_if.slave. It carries the op_valid/op_ready issue
//              handshake, the opcode, dst_addr and operands, and the
//              wb_data/wb_addr/wb_en_n/ovf writeback.
// Non-MUL ops are computed and registered on the accept edge, then spend one
// cycle in WB. MUL spends BW cycles in EXEC before WB.
// Define ALU_WB_SAT_EN to saturate overflowing results instead of wrapping.
module alu_wb import alu_pkg::*; #(
    parameter int BW    = 8,
    parameter int DEPTH = 256
) (
    input  logic   clk,
    input  logic   rst,
    alu_wb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (BW > 1) ? $clog2(BW) : 1;

    state_t                state_q, state_d;
    logic [BW-1:0]         wb_data_q, wb_data_d;
    logic [AW-1:0]         wb_addr_q, wb_addr_d, dst_q, dst_d;
    logic                  ovf_q, ovf_d;

    logic                  accept, mul_start, mul_busy, mul_done;
    logic signed [2*BW-1:0] mul_prod;
    logic [BW:0]           sum_ext;
    logic [BW-1:0]         alu_res, mul_res;
    logic                  alu_ovf, mul_ovf;

    assign accept    = bus.op_valid && (state_q == IDLE);
    assign mul_start = accept && (bus.opcode == OP_MUL);

    alu_mul_iter #(.BW(BW)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.operand_a),
        .b       (bus.operand_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle datapath. ADD/SUB use one extra bit, so the top bit is
    // the sign of the true result.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                sum_ext = {bus.operand_a[BW-1], bus.operand_a} + {bus.operand_b[BW-1], bus.operand_b};
                alu_res = sum_ext[BW-1:0];
                alu_ovf = sum_ext[BW] ^ sum_ext[BW-1];
            end
            OP_SUB: begin
                sum_ext = {bus.operand_a[BW-1], bus.operand_a} - {bus.operand_b[BW-1], bus.operand_b};
                alu_res = sum_ext[BW-1:0];
                alu_ovf = sum_ext[BW] ^ sum_ext[BW-1];
            end
            OP_AND:   alu_res = bus.operand_a & bus.operand_b;
            OP_OR:    alu_res = bus.operand_a | bus.operand_b;
            OP_XOR:   alu_res = bus.operand_a ^ bus.operand_b;
            OP_PASSA: alu_res = bus.operand_a;
            OP_SRA:   alu_res = $unsigned(bus.operand_a >>> bus.operand_b[SW-1:0]);
            default:  alu_res = '0;
        endcase
`ifdef ALU_WB_SAT_EN
        if (alu_ovf) alu_res = BW'(sat_bw(sum_ext[BW], BW));
`endif
    end

    // The product fits in BW signed bits only when its upper BW+1 bits all
    // match the sign bit.
    always_comb begin
        mul_ovf = (mul_prod[2*BW-1:BW-1] != '0) && (mul_prod[2*BW-1:BW-1] != '1);
        mul_res = mul_prod[BW-1:0];
`ifdef ALU_WB_SAT_EN
        if (mul_ovf) mul_res = BW'(sat_bw(mul_prod[2*BW-1], BW));
`endif
    end

    // wb_data/wb_addr/ovf change only when entering WB. They hold between writes.
    always_comb begin
        state_d   = state_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        ovf_d     = ovf_q;
        dst_d     = dst_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dst_d = bus.dst_addr;
                    if (bus.opcode == OP_MUL) begin
                        state_d = EXEC;
                    end else begin
                        state_d   = WB;
                        wb_data_d = alu_res;
                        wb_addr_d = bus.dst_addr;
                        ovf_d     = alu_ovf;
                    end
                end
            end
            EXEC: begin
                if (mul_done) begin
                    state_d   = WB;
                    wb_data_d = mul_res;
                    wb_addr_d = dst_q;
                    ovf_d     = mul_ovf;
                end else if (!mul_busy) begin
                    // Multiplier idle without finishing: recover rather than hang.
                    state_d = IDLE;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            ovf_q     <= 1'b0;
            dst_q     <= '0;
        end else begin
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            ovf_q     <= ovf_d;
            dst_q     <= dst_d;
        end
    end

    assign bus.op_ready = (state_q == IDLE);
    assign bus.wb_en_n  = (state_q != WB);
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.ovf      = ovf_q;

endmodule
